periph_demux4: RTL and testbench

Registered 1-to-4 demultiplexer for the Peripheral_Unit. It steers a single valid/ready request stream to one of four peripheral lanes, selected per beat by a 2-bit code. Beats leave in strict arrival order. A two-entry skid buffer keeps IN_READY registered, so no combinational path runs from any OUT_READY to IN_READY. It is the distributing counterpart of the 4:1 selection mux: lane codes 00/01/10/11 map to lanes A/B/C/D (0..3).

---
 rtl/periph_pkg.sv | 41 ++++
 rtl/periph_demux4_if.sv | 30 +++
 rtl/periph_demux4_chk.sv | 37 +++
 rtl/periph_skid_reg.sv | 118 +++++++++++
 rtl/periph_demux4.sv | 82 ++++++++
 tb/tb_periph_demux4.sv | 203 ++++++++++++++++++++
 6 files changed

// File: rtl/periph_pkg.sv
// -----------------------------------------------------------------------------
// periph_pkg
// Shared types and helpers for the peripheral lane demultiplexer.
//   NUM_LANES   : number of downstream lanes (A..D)
//   lane_sel_t  : 2-bit lane code, 0=A 1=B 2=C 3=D
//   dmx_state_t : buffer occupancy seen from outside (EMPTY/ONE/FULL)
//   lane_onehot : lane code -> one-hot lane vector
//   state_of    : head/skid valid flags -> occupancy state
// -----------------------------------------------------------------------------
package periph_pkg;

   localparam int NUM_LANES = 4;

   typedef logic [1:0] lane_sel_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } dmx_state_t;

   function automatic logic [NUM_LANES-1:0] lane_onehot(input lane_sel_t sel);
      logic [NUM_LANES-1:0] v;
      v      = {NUM_LANES{1'b0}};
      v[sel] = 1'b1;
      return v;
   endfunction

   // A skid entry without a head entry cannot occur; it folds onto EMPTY.
   function automatic dmx_state_t state_of(input logic h_valid, input logic s_valid);
      dmx_state_t st;
      case ({h_valid, s_valid})
         2'b00:   st = EMPTY;
         2'b10:   st = ONE;
         2'b11:   st = FULL;
         default: st = EMPTY;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/periph_demux4_if.sv
// -----------------------------------------------------------------------------
// periph_demux4_if
// Request stream in, four lane-qualified valid/ready streams out.
//   in_valid/in_ready/in_sel/in_data : upstream beat and its destination lane
//   out_valid[3:0]/out_ready[3:0]    : per-lane handshake, out_valid one-hot
//   out_data                         : shared payload bus for all lanes
// master = traffic source/sink around the block, slave = the demux itself.
// -----------------------------------------------------------------------------
interface periph_demux4_if #(parameter int WIDTH = 1);
   import periph_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   lane_sel_t            in_sel;
   logic [WIDTH-1:0]     in_data;
   logic [NUM_LANES-1:0] out_valid;
   logic [NUM_LANES-1:0] out_ready;
   logic [WIDTH-1:0]     out_data;

   modport master (
      output in_valid, in_sel, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_sel, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/periph_demux4_chk.sv
// -----------------------------------------------------------------------------
// periph_demux4_chk
// Property checker for periph_demux4 output behaviour.
//   i_clk, i_rst_n : clock and synchronous active-low reset of the demux
//   i_out_valid    : lane valids, must be one-hot or zero
//   i_out_ready    : lane readies, used to detect an output fire
//   i_out_data     : shared payload, must hold while the head waits
//   i_in_ready     : upstream ready, must be low whenever both entries are used
//   i_state        : buffer occupancy
// -----------------------------------------------------------------------------
module periph_demux4_chk
   import periph_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input logic                 i_clk,
   input logic                 i_rst_n,
   input logic [NUM_LANES-1:0] i_out_valid,
   input logic [NUM_LANES-1:0] i_out_ready,
   input logic [WIDTH-1:0]     i_out_data,
   input logic                 i_in_ready,
   input dmx_state_t           i_state
);

   logic w_out_fire;

   assign w_out_fire = |(i_out_valid & i_out_ready);

   a_onehot_valid : assert property (@(posedge i_clk) $onehot0(i_out_valid));

   a_full_blocks_input : assert property (@(posedge i_clk) (i_state == FULL) |-> !i_in_ready);

   a_head_stable : assert property (@(posedge i_clk)
      (i_rst_n && (|i_out_valid) && !w_out_fire) |=>
         ($stable(i_out_valid) && $stable(i_out_data)));

endmodule

// File: rtl/periph_skid_reg.sv
// -----------------------------------------------------------------------------
// periph_skid_reg
// Two-entry skid buffer. The head entry drives the output side; the skid entry
// absorbs the beat accepted in the cycle the output stalls, which lets the
// input ready come straight from a flop.
//   i_clk, i_rst_n           : clock, synchronous active-low reset
//   i_valid/o_ready/i_data   : input side
//   o_valid/i_ready/o_data   : output side (head entry)
//   o_skid_valid             : skid entry occupied (for occupancy tracking)
// -----------------------------------------------------------------------------
module periph_skid_reg #(
   parameter int DATA_W = 3
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic              o_skid_valid
);

   logic              r_h_valid;
   logic [DATA_W-1:0] r_h_data;
   logic              r_s_valid;
   logic [DATA_W-1:0] r_s_data;
   logic              r_in_ready;

   logic              w_in_fire;
   logic              w_out_fire;
   logic              w_h_valid_nx;
   logic [DATA_W-1:0] w_h_data_nx;
   logic              w_s_valid_nx;
   logic [DATA_W-1:0] w_s_data_nx;
   logic              w_in_ready_nx;

   assign w_in_fire  = i_valid & r_in_ready;
   assign w_out_fire = r_h_valid & i_ready;

   // Next-state for head and skid entries from the occupancy and both fires.
   always_comb begin
      w_h_valid_nx = r_h_valid;
      w_h_data_nx  = r_h_data;
      w_s_valid_nx = r_s_valid;
      w_s_data_nx  = r_s_data;
      case ({r_h_valid, r_s_valid})
         2'b00: begin
            if (w_in_fire) begin
               w_h_valid_nx = 1'b1;
               w_h_data_nx  = i_data;
            end else begin
               w_h_valid_nx = 1'b0;
            end
         end
         2'b10: begin
            case ({w_in_fire, w_out_fire})
               2'b10: begin
                  w_s_valid_nx = 1'b1;
                  w_s_data_nx  = i_data;
               end
               2'b01: begin
                  w_h_valid_nx = 1'b0;
               end
               2'b11: begin
                  // head leaves and the new beat takes its place
                  w_h_data_nx = i_data;
               end
               default: begin
                  w_h_valid_nx = 1'b1;
               end
            endcase
         end
         2'b11: begin
            // input is blocked here because o_ready was registered low
            if (w_out_fire) begin
               w_h_data_nx  = r_s_data;
               w_s_valid_nx = 1'b0;
            end else begin
               w_s_valid_nx = 1'b1;
            end
         end
         default: begin
            w_h_valid_nx = 1'b0;
            w_s_valid_nx = 1'b0;
         end
      endcase
   end

   // Ready for the next cycle is known now, so it can be registered.
   always_comb begin
      w_in_ready_nx = ~(w_h_valid_nx & w_s_valid_nx);
   end

   // Storage registers with synchronous reset that drops any buffered beat.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_h_valid  <= 1'b0;
         r_h_data   <= {DATA_W{1'b0}};
         r_s_valid  <= 1'b0;
         r_s_data   <= {DATA_W{1'b0}};
         r_in_ready <= 1'b0;
      end else begin
         r_h_valid  <= w_h_valid_nx;
         r_h_data   <= w_h_data_nx;
         r_s_valid  <= w_s_valid_nx;
         r_s_data   <= w_s_data_nx;
         r_in_ready <= w_in_ready_nx;
      end
   end

   assign o_ready      = r_in_ready;
   assign o_valid      = r_h_valid;
   assign o_data       = r_h_data;
   assign o_skid_valid = r_s_valid;

endmodule

// File: rtl/periph_demux4.sv
// -----------------------------------------------------------------------------
// periph_demux4
// Registered 1-to-4 demultiplexer. Beats are buffered in arrival order in a
// two-entry skid buffer; the head beat is presented on the lane named by its
// 2-bit code. Only the ready of that lane can retire it, so a stalled head
// blocks later beats for other lanes (intended head-of-line blocking).
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset, clears all buffered beats
//   bus     : periph_demux4_if slave port (input stream + four output lanes)
// -----------------------------------------------------------------------------
module periph_demux4
   import periph_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input logic            i_clk,
   input logic            i_rst_n,
   periph_demux4_if.slave bus
);

   logic [WIDTH+1:0]     w_in_beat;
   logic [WIDTH+1:0]     w_head;
   logic                 w_head_valid;
   logic                 w_skid_valid;
   logic                 w_in_ready;
   lane_sel_t            w_head_sel;
   logic [WIDTH-1:0]     w_head_data;
   logic                 w_lane_ready;
   logic [NUM_LANES-1:0] w_out_valid;
   dmx_state_t           w_state;

   // lane code travels with the payload as the top two bits
   assign w_in_beat = {bus.in_sel, bus.in_data};

   periph_skid_reg #(
      .DATA_W (WIDTH + 2)
   ) u_skid (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_valid      (bus.in_valid),
      .o_ready      (w_in_ready),
      .i_data       (w_in_beat),
      .o_valid      (w_head_valid),
      .i_ready      (w_lane_ready),
      .o_data       (w_head),
      .o_skid_valid (w_skid_valid)
   );

   assign w_head_sel  = w_head[WIDTH+1:WIDTH];
   assign w_head_data = w_head[WIDTH-1:0];

   // readies of lanes other than the head's destination are ignored
   assign w_lane_ready = bus.out_ready[w_head_sel];

   // Lane decode of the registered head.
   always_comb begin
      if (w_head_valid) begin
         w_out_valid = lane_onehot(w_head_sel);
      end else begin
         w_out_valid = {NUM_LANES{1'b0}};
      end
   end

   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = w_head_data;
   assign bus.in_ready  = w_in_ready;

   assign w_state = state_of(w_head_valid, w_skid_valid);

   periph_demux4_chk #(
      .WIDTH (WIDTH)
   ) u_chk (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_out_valid (w_out_valid),
      .i_out_ready (bus.out_ready),
      .i_out_data  (w_head_data),
      .i_in_ready  (w_in_ready),
      .i_state     (w_state)
   );

endmodule

// File: tb/tb_periph_demux4.sv
// -----------------------------------------------------------------------------
// tb_periph_demux4
// Self-checking bench for periph_demux4 (WIDTH=8): a table of directed
// vectors with constant expectations, hand-written multi-cycle sequences, and
// a random soak, all backed by a FIFO scoreboard model of the demux.
// -----------------------------------------------------------------------------
module tb_periph_demux4;
   import periph_pkg::*;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   periph_demux4_if #(.WIDTH(W)) bus ();

   periph_demux4 #(.WIDTH(W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   typedef struct packed {
      lane_sel_t    sel;
      logic [W-1:0] data;
   } beat_t;

   typedef struct {
      logic         rst_n;
      logic         vld;
      lane_sel_t    sel;
      logic [W-1:0] data;
      logic [3:0]   ordy;
      logic         e_rdy;
      logic [3:0]   e_ov;
      logic [W-1:0] e_od;
   } vec_t;

   beat_t q[$];
   logic  exp_rdy = 1'b0;
   int    checks  = 0;
   int    errors  = 0;
   vec_t  tbl[21];

   function automatic vec_t mk(input logic r, input logic v, input lane_sel_t s,
                               input logic [W-1:0] d, input logic [3:0] o,
                               input logic er, input logic [3:0] eov,
                               input logic [W-1:0] eod);
      vec_t x;
      x.rst_n = r; x.vld = v; x.sel = s; x.data = d; x.ordy = o;
      x.e_rdy = er; x.e_ov = eov; x.e_od = eod;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic v, input lane_sel_t s,
                        input logic [W-1:0] d, input logic [3:0] o);
      rst_n         = r;
      bus.in_valid  = v;
      bus.in_sel    = s;
      bus.in_data   = d;
      bus.out_ready = o;
   endtask

   // Advance one clock; the scoreboard updates from its own view of the fires.
   task automatic tick();
      logic r_s, in_f, out_f;
      r_s   = rst_n;
      in_f  = bus.in_valid & exp_rdy;
      out_f = (q.size() > 0) ? bus.out_ready[q[0].sel] : 1'b0;
      if (in_f) begin
         q.push_back({bus.in_sel, bus.in_data});
      end
      @(posedge clk);
      #1;
      if (!r_s) begin
         q.delete();
         exp_rdy = 1'b0;
      end else begin
         if (out_f) begin
            void'(q.pop_front());
         end
         exp_rdy = (q.size() < 2);
      end
   endtask

   // Compare DUT outputs with the scoreboard head and occupancy.
   task automatic check_model(input string tag);
      logic [1:0] exp_st;
      chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, {31'd0, exp_rdy});
      if (q.size() == 0) begin
         chk({tag, ".out_valid"}, {28'd0, bus.out_valid}, 32'd0);
      end else begin
         chk({tag, ".out_valid"}, {28'd0, bus.out_valid}, {28'd0, lane_onehot(q[0].sel)});
         chk({tag, ".out_data"}, {24'd0, bus.out_data}, {24'd0, q[0].data});
      end
      exp_st = (q.size() == 0) ? 2'd0 : ((q.size() == 1) ? 2'd1 : 2'd2);
      chk({tag, ".state"}, {30'd0, dut.w_state}, {30'd0, exp_st});
   endtask

   initial begin
      drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);

      // reset, then a single beat to lane C
      tbl[0]  = mk(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, 4'b0000, 8'h00);
      tbl[1]  = mk(1'b0, 1'b1, 2'd1, 8'h77, 4'b1111, 1'b0, 4'b0000, 8'h00);
      tbl[2]  = mk(1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'h00);
      tbl[3]  = mk(1'b1, 1'b1, 2'd2, 8'h01, 4'b1111, 1'b1, 4'b0100, 8'h01);
      tbl[4]  = mk(1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'h00);
      // back-to-back streaming to all four lanes
      tbl[5]  = mk(1'b1, 1'b1, 2'd0, 8'h10, 4'b1111, 1'b1, 4'b0001, 8'h10);
      tbl[6]  = mk(1'b1, 1'b1, 2'd1, 8'h11, 4'b1111, 1'b1, 4'b0010, 8'h11);
      tbl[7]  = mk(1'b1, 1'b1, 2'd2, 8'h12, 4'b1111, 1'b1, 4'b0100, 8'h12);
      tbl[8]  = mk(1'b1, 1'b1, 2'd3, 8'h13, 4'b1111, 1'b1, 4'b1000, 8'h13);
      tbl[9]  = mk(1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'h00);
      // stall into FULL, input ignored while full, then ordered drain
      tbl[10] = mk(1'b1, 1'b1, 2'd1, 8'h21, 4'b0000, 1'b1, 4'b0010, 8'h21);
      tbl[11] = mk(1'b1, 1'b1, 2'd3, 8'h23, 4'b0000, 1'b0, 4'b0010, 8'h21);
      tbl[12] = mk(1'b1, 1'b1, 2'd0, 8'h99, 4'b0000, 1'b0, 4'b0010, 8'h21);
      tbl[13] = mk(1'b1, 1'b0, 2'd0, 8'h00, 4'b0010, 1'b1, 4'b1000, 8'h23);
      tbl[14] = mk(1'b1, 1'b0, 2'd0, 8'h00, 4'b0010, 1'b1, 4'b1000, 8'h23);
      tbl[15] = mk(1'b1, 1'b0, 2'd0, 8'h00, 4'b1000, 1'b1, 4'b0000, 8'h00);
      // reset while FULL drops both beats
      tbl[16] = mk(1'b1, 1'b1, 2'd2, 8'h31, 4'b0000, 1'b1, 4'b0100, 8'h31);
      tbl[17] = mk(1'b1, 1'b1, 2'd1, 8'h32, 4'b0000, 1'b0, 4'b0100, 8'h31);
      tbl[18] = mk(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, 4'b0000, 8'h00);
      tbl[19] = mk(1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'h00);
      tbl[20] = mk(1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'h00);

      for (int i = 0; i < 21; i++) begin
         drive(tbl[i].rst_n, tbl[i].vld, tbl[i].sel, tbl[i].data, tbl[i].ordy);
         tick();
         chk($sformatf("vec%0d.in_ready", i), {31'd0, bus.in_ready}, {31'd0, tbl[i].e_rdy});
         chk($sformatf("vec%0d.out_valid", i), {28'd0, bus.out_valid}, {28'd0, tbl[i].e_ov});
         if ((tbl[i].e_ov != 4'b0000) || !tbl[i].rst_n) begin
            chk($sformatf("vec%0d.out_data", i), {24'd0, bus.out_data}, {24'd0, tbl[i].e_od});
         end
         check_model($sformatf("vec%0d", i));
      end

      // head for lane A held while only other lanes are ready
      drive(1'b1, 1'b1, 2'd0, 8'h5A, 4'b1110);
      tick();
      check_model("hold.load");
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b0, lane_sel_t'(i % 4), 8'(i * 7), 4'b1110);
         tick();
         chk("hold.out_valid", {28'd0, bus.out_valid}, 32'h1);
         chk("hold.out_data", {24'd0, bus.out_data}, 32'h5A);
      end
      drive(1'b1, 1'b0, 2'd0, 8'h00, 4'b1111);
      tick();
      chk("hold.release", {28'd0, bus.out_valid}, 32'h0);
      check_model("hold.release");

      // one-cycle stall inside a stream: ready drops, nothing lost
      for (int c = 0; c < 10; c++) begin
         drive(1'b1, 1'b1, lane_sel_t'(c % 4), 8'(8'h40 + c), (c == 2) ? 4'b0000 : 4'b1111);
         tick();
         if (c == 2) begin
            chk("stall.in_ready_drop", {31'd0, bus.in_ready}, 32'h0);
         end
         if (c == 3) begin
            chk("stall.in_ready_back", {31'd0, bus.in_ready}, 32'h1);
         end
         check_model("stall");
      end

      // random soak with occasional resets
      for (int c = 0; c < 10000; c++) begin
         logic [3:0] o;
         for (int b = 0; b < 4; b++) begin
            o[b] = ($urandom_range(0, 3) != 0);
         end
         drive(($urandom_range(0, 799) != 0), 1'($urandom_range(0, 1)),
               lane_sel_t'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), o);
         tick();
         check_model("soak");
      end

      // drain whatever is left (two beats at most)
      drive(1'b1, 1'b0, 2'd0, 8'h00, 4'b1111);
      for (int c = 0; c < 4; c++) begin
         tick();
         check_model("drain");
      end
      chk("drain.out_valid", {28'd0, bus.out_valid}, 32'h0);
      chk("drain.in_ready", {31'd0, bus.in_ready}, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
